// File: rtl/counter_sched.sv
// counter_sched: a single shared interval counter time-multiplexed between
// NREQ requesters. An idle block grants the counter round-robin to one
// requester, which then owns it for its latched interval length (0 = 2^CW
// cycles) or until aborted. Completion is signalled by a one-cycle done
// pulse to the finishing owner.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous active-high reset
//   req    in   [NREQ]      level-sensitive request lines
//   dur    in   [NREQ*CW]   requested interval length, requester i on [i*CW +: CW]
//   abort  in   cancel the running interval (ignored when idle)
//   gnt    out  [NREQ]      one-hot current owner, zero when idle
//   owner  out  [clog2]     index of current or most recent owner
//   busy   out  high while an interval runs
//   count  out  [CW]        shared counter value
//   done   out  [NREQ]      one-cycle completion pulse to the finishing owner
module counter_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*CW-1:0]        dur,
   input  logic                      abort,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy,
   output logic [CW-1:0]             count,
   output logic [NREQ-1:0]           done
);

   localparam int unsigned OW = $clog2(NREQ);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [OW-1:0]   last, last_nxt;
   logic [CW-1:0]   len, len_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [OW-1:0]   owner_nxt;
   logic            busy_nxt;
   logic [CW-1:0]   count_nxt;
   logic [NREQ-1:0] done_nxt;

   logic            found;
   logic [OW-1:0]   win;
   logic [CW-1:0]   win_dur;
   logic            last_tick;
   int              idx;

   // Round-robin search starting one past the previous owner.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         idx = int'(last) + k;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = OW'(idx);
         end
      end
   end

   // Interval length requested by the arbitration winner.
   always_comb begin
      win_dur = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (OW'(i) == win) win_dur = dur[i*CW +: CW];
      end
   end

   // len-1 wraps to all-ones for len==0, giving a full 2^CW-cycle interval.
   assign last_tick = (count == (len - CW'(1)));

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      len_nxt   = len;
      gnt_nxt   = gnt;
      owner_nxt = owner;
      busy_nxt  = busy;
      count_nxt = count;
      done_nxt  = '0;

      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = RUN;
               gnt_nxt   = NREQ'(1) << win;
               owner_nxt = win;
               len_nxt   = win_dur;
               count_nxt = '0;
               busy_nxt  = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               // Abort wins over a coinciding completion: no done pulse.
               state_nxt = IDLE;
               gnt_nxt   = '0;
               count_nxt = '0;
               busy_nxt  = 1'b0;
               last_nxt  = owner;
            end else if (last_tick) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               count_nxt = '0;
               busy_nxt  = 1'b0;
               done_nxt  = gnt;
               last_nxt  = owner;
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            count_nxt = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; last resets to NREQ-1 so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         last  <= OW'(NREQ - 1);
         len   <= '0;
         gnt   <= '0;
         owner <= '0;
         busy  <= 1'b0;
         count <= '0;
         done  <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         len   <= len_nxt;
         gnt   <= gnt_nxt;
         owner <= owner_nxt;
         busy  <= busy_nxt;
         count <= count_nxt;
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched (NREQ=4, CW=4): a table of directed
// vectors, hand-written corner sequences and random stimulus, all compared
// against a cycle-level reference model kept in the bench.
module tb_counter_sched;

   localparam int NREQ = 4;
   localparam int CW   = 4;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*CW-1:0] dur;
   logic              abort;
   logic [NREQ-1:0]   gnt;
   logic [1:0]        owner;
   logic              busy;
   logic [CW-1:0]     count;
   logic [NREQ-1:0]   done;

   int checks = 0;
   int errors = 0;

   counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
      .clk(clk), .reset(reset), .req(req), .dur(dur), .abort(abort),
      .gnt(gnt), .owner(owner), .busy(busy), .count(count), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remembers who runs, for how long, and how far along.
   bit m_busy;
   int m_owner, m_last, m_total, m_elapsed;
   int m_done;

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_elapsed = 0; m_total = 0; m_done = 0;
   endtask

   task automatic model_edge();
      int c, d;
      m_done = 0;
      if (reset) begin
         model_reset();
      end else if (m_busy) begin
         if (abort) begin
            m_busy = 0; m_last = m_owner; m_elapsed = 0;
         end else if (m_elapsed + 1 == m_total) begin
            m_busy = 0; m_last = m_owner; m_elapsed = 0; m_done = 1 << m_owner;
         end else begin
            m_elapsed++;
         end
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (!m_busy && req[c]) begin
               d = int'(dur[c*CW +: CW]);
               m_busy = 1; m_owner = c; m_elapsed = 0;
               m_total = (d == 0) ? (1 << CW) : d;
            end
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply current inputs over one edge, advance the model, compare all outputs.
   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      check("gnt",   int'(gnt),   m_busy ? (1 << m_owner) : 0);
      check("owner", int'(owner), m_owner);
      check("busy",  int'(busy),  int'(m_busy));
      check("count", int'(count), m_busy ? m_elapsed : 0);
      check("done",  int'(done),  m_done);
   endtask

   task automatic set_in(input int r, input int a, input int rs);
      req = NREQ'(r); abort = 1'(a); reset = 1'(rs);
   endtask

   task automatic set_dur(input int i, input int v);
      dur[i*CW +: CW] = CW'(v);
   endtask

   task automatic do_reset();
      set_in(0, 0, 1);
      step();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0] r;
      logic [3:0] d0;
      logic       rs;
      logic [3:0] e_gnt;
      logic [3:0] e_cnt;
      logic       e_busy;
      logic [3:0] e_done;
   } vec_t;

   vec_t vt[7];
   int gcount, gmax, order[$], seen;
   bit prev_g;

   initial begin
      model_reset();
      req = '0; dur = '0; abort = 1'b0; reset = 1'b1;

      // Single request of length 3 right after reset.
      vt[0] = '{4'b0000, 4'd3, 1'b1, 4'b0000, 4'd0, 1'b0, 4'b0000};
      vt[1] = '{4'b0001, 4'd3, 1'b0, 4'b0001, 4'd0, 1'b1, 4'b0000};
      vt[2] = '{4'b0001, 4'd3, 1'b0, 4'b0001, 4'd1, 1'b1, 4'b0000};
      vt[3] = '{4'b0001, 4'd3, 1'b0, 4'b0001, 4'd2, 1'b1, 4'b0000};
      vt[4] = '{4'b0000, 4'd3, 1'b0, 4'b0000, 4'd0, 1'b0, 4'b0001};
      vt[5] = '{4'b0000, 4'd3, 1'b0, 4'b0000, 4'd0, 1'b0, 4'b0000};
      vt[6] = '{4'b0000, 4'd3, 1'b0, 4'b0000, 4'd0, 1'b0, 4'b0000};
      for (int i = 0; i < 7; i++) begin
         set_in(int'(vt[i].r), 0, int'(vt[i].rs));
         set_dur(0, int'(vt[i].d0));
         step();
         check("tbl_gnt",  int'(gnt),   int'(vt[i].e_gnt));
         check("tbl_cnt",  int'(count), int'(vt[i].e_cnt));
         check("tbl_busy", int'(busy),  int'(vt[i].e_busy));
         check("tbl_done", int'(done),  int'(vt[i].e_done));
      end

      // Round-robin with all requests held, length 1 each.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_dur(i, 1);
      set_in(4'b1111, 0, 0);
      for (int i = 0; i < 9; i++) begin
         step();
         if (i % 2 == 0) begin
            check("rr_busy", int'(busy), 1);
            order.push_back(int'(owner));
         end else begin
            check("rr_idle", int'(busy), 0);
         end
      end
      check("rr_len", order.size(), 5);
      for (int i = 0; i < order.size(); i++) check("rr_order", order[i], i % NREQ);

      // Length 0 means a full 16-cycle interval.
      do_reset();
      set_dur(1, 0);
      set_in(4'b0010, 0, 0);
      gcount = 0; gmax = 0; seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         step();
         if (gnt == 4'b0010) begin
            gcount++;
            if (int'(count) > gmax) gmax = int'(count);
         end
         if (done == 4'b0010) seen = 1;
      end
      check("wrap_seen", seen, 1);
      check("wrap_cycles", gcount, 16);
      check("wrap_maxcnt", gmax, 15);

      // Abort at count 2; next grant goes to requester 1.
      do_reset();
      set_dur(0, 8); set_dur(1, 2);
      set_in(4'b0011, 0, 0);
      step(); step(); step();
      check("abort_pre_cnt", int'(count), 2);
      abort = 1'b1;
      step();
      check("abort_gnt", int'(gnt), 0);
      check("abort_done", int'(done), 0);
      abort = 1'b0;
      step();
      check("abort_next", int'(gnt), 4'b0010);

      // Abort coinciding with the completion cycle suppresses done.
      step();
      abort = 1'b1;
      step();
      check("abort_last_done", int'(done), 0);
      abort = 1'b0;

      // Reset in the middle of requester 2's run.
      do_reset();
      set_dur(2, 9);
      set_in(4'b0100, 0, 0);
      for (int i = 0; i < 6; i++) step();
      check("rst_pre_cnt", int'(count), 5);
      check("rst_pre_own", int'(owner), 2);
      set_in(4'b0100, 1, 1);
      step();
      check("rst_gnt", int'(gnt), 0);
      check("rst_own", int'(owner), 0);
      set_in(4'b1001, 0, 0);
      step();
      check("rst_first", int'(gnt), 4'b0001);

      // Latched length survives a later dur change.
      do_reset();
      set_dur(0, 4);
      set_in(4'b0001, 0, 0);
      step();
      set_dur(0, 9);
      set_in(4'b0000, 0, 0);
      step(); step(); step();
      check("latch_cnt", int'(count), 3);
      step();
      check("latch_done", int'(done), 4'b0001);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         req   = NREQ'($urandom_range(0, 15));
         dur   = (NREQ*CW)'($urandom);
         abort = ($urandom_range(0, 19) == 0);
         reset = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
